// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master to one-slave AXI read-channel arbiter, one burst at a time.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [LEN_W-1:0]  m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic [1:0]        m0_arlock,
    input  logic [3:0]        m0_arcache,
    input  logic [2:0]        m0_arprot,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [ID_W-1:0]   m0_rid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [LEN_W-1:0]  m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic [1:0]        m1_arlock,
    input  logic [3:0]        m1_arcache,
    input  logic [2:0]        m1_arprot,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [ID_W-1:0]   m1_rid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [LEN_W-1:0]  s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic [1:0]        s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   pick;
    logic   ar_sel_m1;
    logic   burst_done;

    assign burst_done = (state_q == DATA) && s_rvalid && s_rready && s_rlast;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    assign pick = !m0_arvalid;
`else
    logic last_grant_q, last_grant_d;

    // Both requesting: the master not served last wins; otherwise the lone requester.
    assign pick         = (m0_arvalid && m1_arvalid) ? !last_grant_q : m1_arvalid;
    assign last_grant_d = burst_done ? grant_q : last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // NOTE: flops are written only with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_arvalid && s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (burst_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        if (state_q == ADDR) begin
            s_arvalid  = grant_q ? m1_arvalid : m0_arvalid;
            m0_arready = !grant_q && s_arready;
            m1_arready = grant_q && s_arready;
        end
        if (state_q == DATA) begin
            s_rready  = grant_q ? m1_rready : m0_rready;
            m0_rvalid = !grant_q && s_rvalid;
            m1_rvalid = grant_q && s_rvalid;
        end
    end

    // Outside ADDR the AR payload defaults to master 0; s_arvalid is low then.
    assign ar_sel_m1 = (state_q == ADDR) && grant_q;
    assign s_arid    = ar_sel_m1 ? m1_arid    : m0_arid;
    assign s_araddr  = ar_sel_m1 ? m1_araddr  : m0_araddr;
    assign s_arlen   = ar_sel_m1 ? m1_arlen   : m0_arlen;
    assign s_arsize  = ar_sel_m1 ? m1_arsize  : m0_arsize;
    assign s_arburst = ar_sel_m1 ? m1_arburst : m0_arburst;
    assign s_arlock  = ar_sel_m1 ? m1_arlock  : m0_arlock;
    assign s_arcache = ar_sel_m1 ? m1_arcache : m0_arcache;
    assign s_arprot  = ar_sel_m1 ? m1_arprot  : m0_arprot;

    // R payload is broadcast; only rvalid is steered to the winner.
    assign m0_rid   = s_rid;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench with master/slave BFMs and a decoupled AR/R monitor.
// Honours AXI_RD_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_axi_rd_arbiter;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [LEN_W-1:0]  m0_arlen, m1_arlen, s_arlen;
    logic [2:0]        m0_arsize, m1_arsize, s_arsize;
    logic [1:0]        m0_arburst, m1_arburst, s_arburst;
    logic [1:0]        m0_arlock, m1_arlock, s_arlock;
    logic [3:0]        m0_arcache, m1_arcache, s_arcache;
    logic [2:0]        m0_arprot, m1_arprot, s_arprot;
    logic              m0_arvalid, m1_arvalid, s_arvalid;
    logic              m0_arready, m1_arready, s_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]        m0_rresp, m1_rresp, s_rresp;
    logic              m0_rlast, m1_rlast, s_rlast;
    logic              m0_rvalid, m1_rvalid, s_rvalid;
    logic              m0_rready, m1_rready, s_rready;
    logic              grant, busy;

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arlock(m0_arlock), .m0_arcache(m0_arcache), .m0_arprot(m0_arprot),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arlock(m1_arlock), .m1_arcache(m1_arcache), .m1_arprot(m1_arprot),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic        m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } r_t;

    ar_t mq0[$], mq1[$], slv_q[$], ar_exp[$];
    r_t  r_exp0[$], r_exp1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ar_fire_cnt  = 0;
    int ar_fire_cyc  = 0;
    int r0_first_cyc = -1;
    int m0_raise_cyc = 0;
    logic rr1_pat_en = 1'b0;
    int   rr1_idx    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Queue a request at master m and the beats the slave model will return for it.
    task automatic issue(input logic m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        r_t  r;
        a.m = m; a.id = id; a.addr = addr; a.len = len;
        if (m) mq1.push_back(a); else mq0.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            r.id   = id;
            r.data = addr + 32'(i);
            r.last = (i == int'(len));
            if (m) r_exp1.push_back(r); else r_exp0.push_back(r);
        end
    endtask

    task automatic expect_ar(input logic m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.m = m; a.id = id; a.addr = addr; a.len = len;
        ar_exp.push_back(a);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (n < 300 && !(mq0.size() == 0 && mq1.size() == 0 && slv_q.size() == 0 &&
                               r_exp0.size() == 0 && r_exp1.size() == 0 && ar_exp.size() == 0 && !busy));
        if (n >= 300) fail_now(name);
    endtask

    // Master and slave BFMs: sample handshakes mid-cycle, update after the edge.
    initial begin : bfm
        logic f0, f1, ar_f, r_f;
        ar_t  a;
        int   beat = 0;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m1_arid = '0; m1_araddr = '0; m1_arlen = '0;
        m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arlock = 2'd0; m0_arcache = 4'h0; m0_arprot = 3'd0;
        m1_arsize = 3'd2; m1_arburst = 2'd1; m1_arlock = 2'd0; m1_arcache = 4'h3; m1_arprot = 3'd2;
        s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
        forever begin
            @(negedge clk);
            f0   = m0_arvalid && m0_arready;
            f1   = m1_arvalid && m1_arready;
            ar_f = s_arvalid && s_arready;
            r_f  = s_rvalid && s_rready;
            a.m = grant; a.id = s_arid; a.addr = s_araddr; a.len = s_arlen;
            @(posedge clk);
            cyc++;
            if (reset) begin
                slv_q.delete();
                beat = 0;
            end else begin
                if (f0 && mq0.size() > 0) mq0.delete(0);
                if (f1 && mq1.size() > 0) mq1.delete(0);
                if (r_f && slv_q.size() > 0) begin
                    if (beat == int'(slv_q[0].len)) begin
                        slv_q.delete(0);
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (ar_f) slv_q.push_back(a);
            end
            // NOTE: stimulus changes 1 time unit after the edge with blocking assigns, so the DUT never races it.
            #1;
            if (mq0.size() > 0) begin
                if (!m0_arvalid) m0_raise_cyc = cyc;
                m0_arvalid = 1'b1; m0_arid = mq0[0].id; m0_araddr = mq0[0].addr; m0_arlen = mq0[0].len;
            end else begin
                m0_arvalid = 1'b0;
            end
            if (mq1.size() > 0) begin
                m1_arvalid = 1'b1; m1_arid = mq1[0].id; m1_araddr = mq1[0].addr; m1_arlen = mq1[0].len;
            end else begin
                m1_arvalid = 1'b0;
            end
            if (rr1_pat_en) begin
                m1_rready = pat[rr1_idx % 4];
                rr1_idx++;
            end
            if (slv_q.size() > 0) begin
                s_rvalid = 1'b1;
                s_rid    = slv_q[0].id;
                s_rdata  = slv_q[0].addr + 32'(beat);
                s_rlast  = (beat == int'(slv_q[0].len));
            end else begin
                s_rvalid = 1'b0;
                s_rlast  = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an AR or R handshake.
    ar_t mon_a;
    r_t  mon_r;
    always @(negedge clk) begin
        if (!reset) begin
            if (s_arvalid && s_arready) begin
                if (ar_exp.size() == 0) begin
                    fail_now("ar_unexpected");
                end else begin
                    mon_a = ar_exp.pop_front();
                    check("ar_grant", 64'(grant), 64'(mon_a.m));
                    check("ar_addr", 64'(s_araddr), 64'(mon_a.addr));
                    check("ar_id", 64'(s_arid), 64'(mon_a.id));
                    check("ar_len", 64'(s_arlen), 64'(mon_a.len));
                    check("ar_prot", 64'(s_arprot), mon_a.m ? 64'd2 : 64'd0);
                    check("ar_cache", 64'(s_arcache), mon_a.m ? 64'd3 : 64'd0);
                    check("ar_ready_win", 64'(mon_a.m ? m1_arready : m0_arready), 64'd1);
                    check("ar_ready_lose", 64'(mon_a.m ? m0_arready : m1_arready), 64'd0);
                    ar_fire_cnt++;
                    ar_fire_cyc = cyc;
                end
            end
            if (m0_rvalid && m1_rvalid) fail_now("r_both_valid");
            if (m0_rvalid && r_exp0.size() == 0) fail_now("r0_spurious");
            if (m1_rvalid && r_exp1.size() == 0) fail_now("r1_spurious");
            if (m1_rvalid) check("r1_rready_mirror", 64'(s_rready), 64'(m1_rready));
            if (m0_rvalid && m0_rready && r_exp0.size() > 0) begin
                mon_r = r_exp0.pop_front();
                check("r0_data", 64'(m0_rdata), 64'(mon_r.data));
                check("r0_last", 64'(m0_rlast), 64'(mon_r.last));
                check("r0_id", 64'(m0_rid), 64'(mon_r.id));
                if (r0_first_cyc < 0) r0_first_cyc = cyc;
            end
            if (m1_rvalid && m1_rready && r_exp1.size() > 0) begin
                mon_r = r_exp1.pop_front();
                check("r1_data", 64'(m1_rdata), 64'(mon_r.data));
                check("r1_last", 64'(m1_rlast), 64'(mon_r.last));
                check("r1_id", 64'(m1_rid), 64'(mon_r.id));
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, 64'({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, grant, busy}), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_outputs");
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int cnt0;
        reset = 1'b1;
        s_arready = 1'b1;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        do_reset();

        // Single master, single beat: AR at N+1, rlast one cycle later.
        issue(1'b0, 4'h1, 32'h100, 8'd0);
        expect_ar(1'b0, 4'h1, 32'h100, 8'd0);
        wait_idle("t1_timeout");
        check("t1_lat_ar", 64'(ar_fire_cyc - m0_raise_cyc), 64'd1);
        check("t1_lat_r", 64'(r0_first_cyc - ar_fire_cyc), 64'd1);
        check("t1_grant", 64'(grant), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // Simultaneous request right after reset: master 0 first.
        do_reset();
        issue(1'b0, 4'h2, 32'h200, 8'd3);
        issue(1'b1, 4'h3, 32'h300, 8'd3);
        expect_ar(1'b0, 4'h2, 32'h200, 8'd3);
        expect_ar(1'b1, 4'h3, 32'h300, 8'd3);
        wait_idle("t2_timeout");
        check("t2_grant", 64'(grant), 64'd1);

        // Six back-to-back bursts with both masters always requesting.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 4'h4, 32'h400 + 32'(16 * i), 8'd1);
            issue(1'b1, 4'h5, 32'h500 + 32'(16 * i), 8'd1);
        end
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) expect_ar(1'b0, 4'h4, 32'h400 + 32'(16 * i), 8'd1);
        for (int i = 0; i < 3; i++) expect_ar(1'b1, 4'h5, 32'h500 + 32'(16 * i), 8'd1);
`else
        for (int i = 0; i < 3; i++) begin
            expect_ar(1'b0, 4'h4, 32'h400 + 32'(16 * i), 8'd1);
            expect_ar(1'b1, 4'h5, 32'h500 + 32'(16 * i), 8'd1);
        end
`endif
        wait_idle("t3_timeout");

        // Master 1 burst under rready backpressure 1,0,0,1,...
        rr1_pat_en = 1'b1;
        issue(1'b1, 4'h6, 32'h600, 8'd3);
        expect_ar(1'b1, 4'h6, 32'h600, 8'd3);
        wait_idle("t4_timeout");
        rr1_pat_en = 1'b0;
        m1_rready = 1'b1;

        // Slave holds arready low for 5 cycles in ADDR.
        s_arready = 1'b0;
        cnt0 = ar_fire_cnt;
        issue(1'b0, 4'h7, 32'h700, 8'd1);
        expect_ar(1'b0, 4'h7, 32'h700, 8'd1);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!busy && n < 20);
        if (n >= 20) fail_now("t5_busy_timeout");
        for (int i = 0; i < 5; i++) begin
            check("t5_busy", 64'(busy), 64'd1);
            check("t5_s_arvalid", 64'(s_arvalid), 64'd1);
            check("t5_m0_arready", 64'(m0_arready), 64'd0);
            check("t5_no_fire", 64'(ar_fire_cnt), 64'(cnt0));
            @(negedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        s_arready = 1'b1;
        @(negedge clk);
        #2;
        check("t5_fire", 64'(ar_fire_cnt), 64'(cnt0 + 1));
        wait_idle("t5_timeout");

        // Reset after the second beat of an 8-beat burst.
        issue(1'b0, 4'h8, 32'h800, 8'd7);
        expect_ar(1'b0, 4'h8, 32'h800, 8'd7);
        n = 0;
        while (r_exp0.size() > 6 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) fail_now("t6_beat_timeout");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_rst_outputs");
        reset = 1'b0;
        r_exp0.delete();
        issue(1'b0, 4'h9, 32'h900, 8'd0);
        expect_ar(1'b0, 4'h9, 32'h900, 8'd0);
        wait_idle("t6_timeout");
        check("t6_grant", 64'(grant), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
